video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
- Parametrised raster timing generator for arcade cores. Successor to the fixed 256x224 timing block: geometry, pixel-clock divide and counter width are parameters.
- Screen-centering offsets are shadowed so they take effect only at frame wrap.
- Adds line_start and frame_start strobes for the core logic.
- Sits between clk_sys and both the core and the video output stage. Drives ce_pix, counters, blanking and sync.

Parameters:
- CNT_W, 9, width of hcount and vcount.
- CE_DIV, 4, clk_sys cycles per pixel; legal range 1..16.
- H_TOTAL, 384, pixels per line.
- H_ACTIVE, 256, visible pixels; hcount 0..H_ACTIVE-1.
- HS_START, 304, nominal hsync start.
- HS_WIDTH, 32, hsync length in pixels.
- V_TOTAL, 264, lines per frame.
- V_ACTIVE, 224, visible lines.
- VS_START, 240, nominal vsync start line.
- VS_WIDTH, 4, vsync length in lines.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- hoffs  in  4  signed horizontal centering offset, -8..+7 pixels.
- voffs  in  4  signed vertical centering offset, -8..+7 lines.
- ce_pix  out  1  one-clk_sys pixel enable.
- hcount  out  CNT_W  current pixel.
- vcount  out  CNT_W  current line.
- hb  out  1  horizontal blank, active high.
- vb  out  1  vertical blank, active high.
- hs  out  1  horizontal sync, active high.
- vs  out  1  vertical sync, active high.
- line_start  out  1  high for the ce_pix cycle in which hcount becomes 0.
- frame_start  out  1  high for the ce_pix cycle in which hcount and vcount both become 0.
- line_irq  out  1  present only with VTG_LINE_IRQ_EN.
- irq_line  in  CNT_W  present only with VTG_LINE_IRQ_EN.
- irq_ack  in  1  present only with VTG_LINE_IRQ_EN.

Behaviour:
- Reset state: every output is 0; the divider counter is 0; the shadow offsets are 0.
- Divider: counts 0..CE_DIV-1. ce_pix is registered and high in the cycle where the divider equals CE_DIV-1. With CE_DIV=1, ce_pix is constantly 1 after reset.
- Advance: counters move only on ce_pix.
  - hcount wraps H_TOTAL-1 -> 0 and increments vcount.
  - vcount wraps V_TOTAL-1 -> 0.
- Output alignment: hb, vb, hs, vs, line_start and frame_start are registered from the next-count values, so they change in the same clk_sys edge as the counters. Zero latency relative to hcount/vcount.
- hb = hcount >= H_ACTIVE.
- vb = vcount >= V_ACTIVE.
- Effective sync start: hs_s = (HS_START + sext(hoffs_shadow)) mod H_TOTAL, computed at CNT_W+1 bits.
  - hs is high for HS_WIDTH pixels starting at hs_s. The window wraps modulo H_TOTAL when it crosses line end.
  - vs is built the same way from VS_START, voffs_shadow, VS_WIDTH and V_TOTAL, evaluated per line.
  - Negative starts wrap upward, e.g. start 2, offset -8, total 264 -> 258.
- Shadowing: hoffs and voffs are sampled into shadows at the ce_pix that produces frame_start. Changes made mid-frame have no effect until the next wrap.
- Parameter check: elaboration fails unless all of the following hold:
  - H_ACTIVE < H_TOTAL and V_ACTIVE < V_TOTAL.
  - HS_WIDTH < H_TOTAL - H_ACTIVE and VS_WIDTH < V_TOTAL - V_ACTIVE.
  - H_TOTAL <= 2**CNT_W and V_TOTAL <= 2**CNT_W.
- Reset mid-frame: takes effect immediately and asynchronously. The first ce_pix after release occurs CE_DIV cycles later with hcount going 0 -> 1. No frame_start fires for that initial position.

Optional Feature:
- Macro: VTG_LINE_IRQ_EN.
- Enabled:
  - line_irq sets at the ce_pix where hcount becomes 0 and vcount becomes irq_line.
  - line_irq holds high until irq_ack is sampled high.
  - If set and ack occur in the same cycle, set wins.
  - An irq_line value >= V_TOTAL never fires.
- Disabled: the line_irq, irq_line and irq_ack ports and their logic are absent.

Decomposition:
- Package video_timing_pkg holds:
  - Galivan default constants (the values above).
  - Typedef cnt_t (logic [CNT_W-1:0] default width 9).
  - Function wrap_add(start, signed offset, total) returning the modulo sum.
- One sub-module, ce_divider: parametrised CE_DIV counter producing ce_pix. Reused by the audio clock-enable path.

Test Plan:
- Reset behaviour: hold reset_n=0 for 10 cycles, then release -> all outputs 0 during reset; first ce_pix at cycle 4 after release; hcount=1.
- Frame timing with defaults: count ce_pix between consecutive frame_start pulses -> 384*264 = 101376; hb rises at hcount=256; vb rises at vcount=224; hs is high for hcount 304..335.
- Offset shadowing: set hoffs=+3 at vcount=100 -> hs stays at 304..335 until the next frame_start, then moves to 307..338; voffs=-8 moves vs to lines 232..235.
- Wrap-around: parameters HS_START=380, HS_WIDTH=8, hoffs=+2 -> hs is high for hcount 382,383,0..5, and the window stays continuous across the line wrap.
- CE_DIV=1 and CE_DIV=3 builds: ce_pix is always 1 in the first, and has period 3 in the second; hcount/vcount sequences are identical to the default build.
- VTG_LINE_IRQ_EN:
  - irq_line=50 -> line_irq rises on the edge where vcount becomes 50 with hcount 0.
  - irq_ack pulsed together with the next set on line 50 of the following frame -> line_irq stays 1.
  - irq_line=300 -> no line_irq.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: default raster constants, counter type and modular helpers
package video_timing_pkg;
  localparam int CNT_W_DEF    = 9;
  localparam int CE_DIV_DEF   = 4;
  localparam int H_TOTAL_DEF  = 384;
  localparam int H_ACTIVE_DEF = 256;
  localparam int HS_START_DEF = 304;
  localparam int HS_WIDTH_DEF = 32;
  localparam int V_TOTAL_DEF  = 264;
  localparam int V_ACTIVE_DEF = 224;
  localparam int VS_START_DEF = 240;
  localparam int VS_WIDTH_DEF = 4;
  typedef logic [CNT_W_DEF-1:0] cnt_t;
  // offsets are limited to -8..+7, so one correction step brings the sum back into range
  function automatic int wrap_add(input int start, input int offset, input int total);
    int s;
    s = start + offset;
    return s < 0 ? s + total : s >= total ? s - total : s;
  endfunction
  function automatic logic in_window(input int pos, input int start, input int width, input int total);
    int d;
    d = pos - start;
    d = d < 0 ? d + total : d;
    return d < width;
  endfunction
endpackage

// File: rtl/video_timing_gen_ce_divider.sv
// ce_divider: free-running 0..CE_DIV-1 counter; tick marks the last count, ce_pix is its registered copy
module ce_divider #(
  parameter int CE_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic tick,
  output logic ce_pix
);
  localparam int DW = CE_DIV > 1 ? $clog2(CE_DIV) : 1;
  logic [DW-1:0] div;
  assign tick = div == DW'(CE_DIV - 1);
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      div    <= '0;
      ce_pix <= 1'b0;
    end else begin
      div    <= tick ? '0 : div + DW'(1);
      ce_pix <= tick;
    end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing with shadowed centering offsets.
// Define VTG_LINE_IRQ_EN to add the line_irq / irq_line / irq_ack raster interrupt.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int CE_DIV   = CE_DIV_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int HS_START = HS_START_DEF,
  parameter int HS_WIDTH = HS_WIDTH_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int VS_START = VS_START_DEF,
  parameter int VS_WIDTH = VS_WIDTH_DEF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic signed [3:0] hoffs,
  input  logic signed [3:0] voffs,
  output logic              ce_pix,
  output logic [CNT_W-1:0]  hcount,
  output logic [CNT_W-1:0]  vcount,
  output logic              hb,
  output logic              vb,
  output logic              hs,
  output logic              vs,
  output logic              line_start,
  output logic              frame_start
`ifdef VTG_LINE_IRQ_EN
  ,
  input  logic [CNT_W-1:0]  irq_line,
  input  logic              irq_ack,
  output logic              line_irq
`endif
);
  if (!(H_ACTIVE < H_TOTAL && V_ACTIVE < V_TOTAL &&
        HS_WIDTH < H_TOTAL - H_ACTIVE && VS_WIDTH < V_TOTAL - V_ACTIVE &&
        H_TOTAL <= 2**CNT_W && V_TOTAL <= 2**CNT_W &&
        CE_DIV >= 1 && CE_DIV <= 16)) begin : g_param_check
    $error("video_timing_gen: illegal timing parameters");
  end
  logic              tick;
  logic              line_end;
  logic              wrap;
  logic [CNT_W-1:0]  h_next;
  logic [CNT_W-1:0]  v_next;
  logic signed [3:0] ho_sh;
  logic signed [3:0] vo_sh;
  logic signed [3:0] ho_eff;
  logic signed [3:0] vo_eff;
  ce_divider #(.CE_DIV(CE_DIV)) u_ce (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .tick(tick),
    .ce_pix(ce_pix)
  );
  assign line_end = hcount == CNT_W'(H_TOTAL - 1);
  assign h_next   = !tick ? hcount : line_end ? '0 : hcount + CNT_W'(1);
  assign v_next   = !(tick && line_end) ? vcount : vcount == CNT_W'(V_TOTAL - 1) ? '0 : vcount + CNT_W'(1);
  assign wrap     = tick && h_next == '0 && v_next == '0;
  // the offset captured at frame wrap already governs the first pixel of the new frame
  assign ho_eff   = wrap ? hoffs : ho_sh;
  assign vo_eff   = wrap ? voffs : vo_sh;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hb          <= 1'b0;
      vb          <= 1'b0;
      hs          <= 1'b0;
      vs          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      ho_sh       <= '0;
      vo_sh       <= '0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hb          <= h_next >= CNT_W'(H_ACTIVE);
      vb          <= v_next >= CNT_W'(V_ACTIVE);
      hs          <= in_window(int'(h_next), wrap_add(HS_START, int'(ho_eff), H_TOTAL), HS_WIDTH, H_TOTAL);
      vs          <= in_window(int'(v_next), wrap_add(VS_START, int'(vo_eff), V_TOTAL), VS_WIDTH, V_TOTAL);
      line_start  <= tick && h_next == '0;
      frame_start <= wrap;
      ho_sh       <= ho_eff;
      vo_sh       <= vo_eff;
    end
`ifdef VTG_LINE_IRQ_EN
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) line_irq <= 1'b0;
    else line_irq <= (tick && h_next == '0 && v_next == irq_line) || (line_irq && !irq_ack);
`endif
endmodule
